// File: rtl/imu_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : imu_burst_sequencer
//  Purpose  : Configures an I2C sensor once, then repeatedly bursts N_BYTES
//             registers through a byte-level I2C master, with NACK retry.
//  Revision : 1.0 - initial release
// ============================================================================
module imu_burst_sequencer #(
   parameter int         N_BYTES   = 14,
   parameter int         ADR_W     = 4,
   parameter logic [7:0] START_REG = 8'h3B,
   parameter logic [7:0] CFG_REG   = 8'h6B,
   parameter logic [7:0] CFG_VAL   = 8'h00,
   parameter int         MAX_RETRY = 3,
   parameter bit         AUTO_SCAN = 1'b0
) (
   input  logic             MCLK,
   input  logic             nRST,
   input  logic             TIC,
   output logic             SRST,
   output logic [7:0]       DOUT,
   output logic             WE,
   output logic             RD,
   input  logic             QUEUED,
   input  logic             NACK,
   input  logic             STOP,
   input  logic             DATA_VALID,
   input  logic [7:0]       DIN,
   output logic [ADR_W-1:0] ADR,
   output logic [7:0]       DATA,
   output logic             LOAD,
   output logic             COMPLETED,
   output logic             ERR,
   input  logic             RESCAN,
   output logic [7:0]       SCAN_CNT
);

   localparam logic [ADR_W:0] c_n_bytes   = (ADR_W+1)'(N_BYTES);
   localparam logic [ADR_W:0] c_idx_one   = (ADR_W+1)'(1);
   localparam logic [3:0]     c_max_retry = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CFG_A     = 3'd1,
      S_CFG_B     = 3'd2,
      S_WAIT_STOP = 3'd3,
      S_PTR       = 3'd4,
      S_READ      = 3'd5,
      S_DONE      = 3'd6,
      S_ERROR     = 3'd7
   } state_t;

   state_t           r_state,     w_state;
   logic             r_srst,      w_srst;
   logic [7:0]       r_dout,      w_dout;
   logic             r_we,        w_we;
   logic             r_rd,        w_rd;
   logic [ADR_W-1:0] r_adr,       w_adr;
   logic [7:0]       r_data,      w_data;
   logic             r_load,      w_load;
   logic             r_completed, w_completed;
   logic             r_err,       w_err;
   logic [7:0]       r_scan_cnt,  w_scan_cnt;
   logic             r_cfg_done,  w_cfg_done;
   logic [2:0]       r_retry,     w_retry;
   logic [ADR_W:0]   r_req,       w_req;
   logic [ADR_W:0]   r_idx,       w_idx;
   logic             w_fail;

   always_comb begin
      w_state     = r_state;
      w_srst      = 1'b0;
      w_dout      = r_dout;
      w_we        = r_we;
      w_rd        = r_rd;
      w_adr       = r_adr;
      w_data      = r_data;
      w_load      = 1'b0;
      w_completed = r_completed;
      w_err       = r_err;
      w_scan_cnt  = r_scan_cnt;
      w_cfg_done  = r_cfg_done;
      w_retry     = r_retry;
      w_req       = r_req;
      w_idx       = r_idx;
      w_fail      = 1'b0;

      if (TIC) begin
         unique case (r_state)
            S_IDLE: begin
               w_completed = 1'b0;
               w_we        = 1'b1;
               if (r_cfg_done) begin
                  w_rd    = 1'b0;
                  w_dout  = START_REG;
                  w_state = S_PTR;
               end else begin
                  w_dout  = CFG_REG;
                  w_state = S_CFG_A;
               end
            end
            S_CFG_A: begin
               if (NACK) w_fail = 1'b1;
               else if (QUEUED) begin
                  w_dout  = CFG_VAL;
                  w_state = S_CFG_B;
               end
            end
            S_CFG_B: begin
               if (NACK) w_fail = 1'b1;
               else if (QUEUED) begin
                  w_we       = 1'b0;
                  w_cfg_done = 1'b1;
                  w_state    = S_WAIT_STOP;
               end
            end
            S_WAIT_STOP: begin
               if (NACK) w_fail = 1'b1;
               else if (STOP) begin
                  w_we    = 1'b1;
                  w_rd    = 1'b0;
                  w_dout  = START_REG;
                  w_state = S_PTR;
               end
            end
            S_PTR: begin
               if (NACK) w_fail = 1'b1;
               else if (QUEUED) begin
                  w_we    = 1'b0;
                  w_rd    = 1'b1;
                  w_req   = '0;
                  w_idx   = '0;
                  w_adr   = '0;
                  w_state = S_READ;
               end
            end
            S_READ: begin
               if (NACK) w_fail = 1'b1;
               else if (STOP) begin
                  // A stop before the full burst arrived is a truncated read
                  if (r_idx == c_n_bytes) begin
                     w_rd        = 1'b0;
                     w_completed = 1'b1;
                     w_scan_cnt  = r_scan_cnt + 8'd1;
                     w_retry     = 3'd0;
                     w_state     = S_DONE;
                  end else begin
                     w_fail = 1'b1;
                  end
               end else if (DATA_VALID) begin
                  if (r_idx != c_n_bytes) begin
                     w_data = DIN;
                     w_adr  = r_idx[ADR_W-1:0];
                     w_load = 1'b1;
                     w_idx  = r_idx + c_idx_one;
                  end
               end else if (QUEUED && r_rd) begin
                  w_req = r_req + c_idx_one;
                  if (r_req + c_idx_one == c_n_bytes) w_rd = 1'b0;
               end
            end
            S_DONE: begin
               if (RESCAN || AUTO_SCAN) w_state = S_IDLE;
            end
            S_ERROR: begin
               if (RESCAN) begin
                  w_err      = 1'b0;
                  w_retry    = 3'd0;
                  w_cfg_done = 1'b0;
                  w_state    = S_IDLE;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end

      if (w_fail) begin
         w_we   = 1'b0;
         w_rd   = 1'b0;
         w_srst = 1'b1;
         if (({1'b0, r_retry} + 4'd1) < c_max_retry) begin
            w_retry = r_retry + 3'd1;
            w_state = S_IDLE;
         end else begin
            w_err       = 1'b1;
            w_completed = 1'b0;
            w_state     = S_ERROR;
         end
      end
   end

   always_ff @(posedge MCLK) begin
      if (!nRST) begin
         r_state     <= S_IDLE;
         r_srst      <= 1'b0;
         r_dout      <= 8'h00;
         r_we        <= 1'b0;
         r_rd        <= 1'b0;
         r_adr       <= '0;
         r_data      <= 8'hFF;
         r_load      <= 1'b0;
         r_completed <= 1'b0;
         r_err       <= 1'b0;
         r_scan_cnt  <= 8'h00;
         r_cfg_done  <= 1'b0;
         r_retry     <= 3'd0;
         r_req       <= '0;
         r_idx       <= '0;
      end else begin
         r_state     <= w_state;
         r_srst      <= w_srst;
         r_dout      <= w_dout;
         r_we        <= w_we;
         r_rd        <= w_rd;
         r_adr       <= w_adr;
         r_data      <= w_data;
         r_load      <= w_load;
         r_completed <= w_completed;
         r_err       <= w_err;
         r_scan_cnt  <= w_scan_cnt;
         r_cfg_done  <= w_cfg_done;
         r_retry     <= w_retry;
         r_req       <= w_req;
         r_idx       <= w_idx;
      end
   end

   assign SRST      = r_srst;
   assign DOUT      = r_dout;
   assign WE        = r_we;
   assign RD        = r_rd;
   assign ADR       = r_adr;
   assign DATA      = r_data;
   assign LOAD      = r_load;
   assign COMPLETED = r_completed;
   assign ERR       = r_err;
   assign SCAN_CNT  = r_scan_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imu_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imu_burst_sequencer
//  Purpose  : Directed self-checking bench for imu_burst_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imu_burst_sequencer;

   localparam logic [4:0] E_NONE = 5'd0, E_Q = 5'd1, E_DV = 5'd2, E_ST = 5'd4,
                          E_NK = 5'd8, E_RS = 5'd16;
   localparam logic [33:0] RST_EXP = {1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'hFF,
                                      1'b0, 1'b0, 1'b0, 8'h00};

   logic MCLK = 1'b0, nRST = 1'b0, TIC = 1'b1;
   logic QUEUED = 1'b0, NACK = 1'b0, STOP = 1'b0, DATA_VALID = 1'b0, RESCAN = 1'b0;
   logic [7:0] DIN = 8'h00;
   logic SRST, WE, RD, LOAD, COMPLETED, ERR;
   logic [7:0] DOUT, DATA, SCAN_CNT;
   logic [3:0] ADR;

   logic q1 = 1'b0, n1 = 1'b0, s1 = 1'b0, dv1 = 1'b0, rs1 = 1'b0;
   logic SRST1, WE1, RD1, LOAD1, COMPLETED1, ERR1;
   logic [7:0] DOUT1, DATA1, SCAN_CNT1;
   logic [0:0] ADR1;

   int  checks = 0, failures = 0;
   bit  tgt = 1'b0;

   always #5 MCLK = ~MCLK;

   imu_burst_sequencer u_dut (
      .MCLK(MCLK), .nRST(nRST), .TIC(TIC), .SRST(SRST), .DOUT(DOUT), .WE(WE), .RD(RD),
      .QUEUED(QUEUED), .NACK(NACK), .STOP(STOP), .DATA_VALID(DATA_VALID), .DIN(DIN),
      .ADR(ADR), .DATA(DATA), .LOAD(LOAD), .COMPLETED(COMPLETED), .ERR(ERR),
      .RESCAN(RESCAN), .SCAN_CNT(SCAN_CNT)
   );

   imu_burst_sequencer #(.N_BYTES(1), .ADR_W(1), .AUTO_SCAN(1'b1)) u_dut1 (
      .MCLK(MCLK), .nRST(nRST), .TIC(TIC), .SRST(SRST1), .DOUT(DOUT1), .WE(WE1), .RD(RD1),
      .QUEUED(q1), .NACK(n1), .STOP(s1), .DATA_VALID(dv1), .DIN(DIN),
      .ADR(ADR1), .DATA(DATA1), .LOAD(LOAD1), .COMPLETED(COMPLETED1), .ERR(ERR1),
      .RESCAN(rs1), .SCAN_CNT(SCAN_CNT1)
   );

   // Present one cycle of handshake events, then sample 1 time unit after the edge.
   task automatic step(input logic [4:0] ev, input logic [7:0] din);
      if (!tgt) {RESCAN, NACK, STOP, DATA_VALID, QUEUED} = ev;
      else      {rs1, n1, s1, dv1, q1} = ev;
      DIN = din;
      @(posedge MCLK);
      #1;
      {RESCAN, NACK, STOP, DATA_VALID, QUEUED} = 5'd0;
      {rs1, n1, s1, dv1, q1} = 5'd0;
   endtask

   // From PTR: address accepted, all read requests accepted, then n_dv bytes.
   task automatic do_burst(input int n_dv, input logic [7:0] base);
      step(E_Q, 8'h00);
      repeat (14) step(E_Q, 8'h00);
      for (int i = 0; i < n_dv; i++) step(E_DV, 8'(base + i));
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      step(E_NONE, 8'h00);
      step(E_NONE, 8'h00);
      checks++;
      if ({SRST, DOUT, WE, RD, ADR, DATA, LOAD, COMPLETED, ERR, SCAN_CNT} !== RST_EXP) begin
         failures++;
         $display("FAIL reset_state: got %h required %h",
                  {SRST, DOUT, WE, RD, ADR, DATA, LOAD, COMPLETED, ERR, SCAN_CNT}, RST_EXP);
      end
   endtask

   task automatic test_first_scan;
      nRST = 1'b1;
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h6B) begin
         failures++; $display("FAIL cfg_reg: WE=%b DOUT=%h required 1 6b", WE, DOUT);
      end
      step(E_Q, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h00) begin
         failures++; $display("FAIL cfg_val: WE=%b DOUT=%h required 1 00", WE, DOUT);
      end
      step(E_Q, 8'h00);
      checks++;
      if (WE !== 1'b0) begin
         failures++; $display("FAIL cfg_end: WE=%b required 0", WE);
      end
      step(E_ST, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h3B) begin
         failures++; $display("FAIL ptr_first: WE=%b DOUT=%h required 1 3b", WE, DOUT);
      end
      step(E_Q, 8'h00);
      checks++;
      if (WE !== 1'b0 || RD !== 1'b1 || ADR !== 4'd0) begin
         failures++; $display("FAIL read_start: WE=%b RD=%b ADR=%0d required 0 1 0", WE, RD, ADR);
      end
      for (int i = 0; i < 14; i++) begin
         step(E_Q, 8'h00);
         checks++;
         if (RD !== (i != 13) || LOAD !== 1'b0) begin
            failures++;
            $display("FAIL read_req%0d: RD=%b LOAD=%b required %b 0", i, RD, LOAD, (i != 13));
         end
         step(E_DV, 8'(8'h10 + i));
         checks++;
         if (LOAD !== 1'b1 || ADR !== 4'(i) || DATA !== 8'(8'h10 + i)) begin
            failures++;
            $display("FAIL load%0d: LOAD=%b ADR=%0d DATA=%h required 1 %0d %h",
                     i, LOAD, ADR, DATA, i, 8'(8'h10 + i));
         end
      end
      step(E_DV, 8'hAA);
      checks++;
      if (LOAD !== 1'b0 || DATA !== 8'h1D || ADR !== 4'd13) begin
         failures++;
         $display("FAIL extra_dv: LOAD=%b DATA=%h ADR=%0d required 0 1d 13", LOAD, DATA, ADR);
      end
      step(E_ST, 8'h00);
      checks++;
      if (COMPLETED !== 1'b1 || SCAN_CNT !== 8'd1 || ERR !== 1'b0) begin
         failures++;
         $display("FAIL scan1_done: COMPLETED=%b SCAN_CNT=%0d ERR=%b required 1 1 0",
                  COMPLETED, SCAN_CNT, ERR);
      end
      repeat (3) step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b0 || COMPLETED !== 1'b1) begin
         failures++;
         $display("FAIL done_hold: WE=%b COMPLETED=%b required 0 1", WE, COMPLETED);
      end
   endtask

   task automatic test_rescan;
      step(E_RS, 8'h00);
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h3B || COMPLETED !== 1'b0) begin
         failures++;
         $display("FAIL rescan_ptr: WE=%b DOUT=%h COMPLETED=%b required 1 3b 0", WE, DOUT, COMPLETED);
      end
      do_burst(14, 8'h20);
      step(E_ST, 8'h00);
      checks++;
      if (SCAN_CNT !== 8'd2 || DATA !== 8'h2D || COMPLETED !== 1'b1) begin
         failures++;
         $display("FAIL scan2_done: SCAN_CNT=%0d DATA=%h COMPLETED=%b required 2 2d 1",
                  SCAN_CNT, DATA, COMPLETED);
      end
   endtask

   task automatic test_nack_ptr;
      step(E_RS, 8'h00);
      step(E_NONE, 8'h00);
      step(E_NK, 8'h00);
      checks++;
      if (SRST !== 1'b1 || WE !== 1'b0) begin
         failures++; $display("FAIL nack_ptr_srst: SRST=%b WE=%b required 1 0", SRST, WE);
      end
      step(E_NONE, 8'h00);
      checks++;
      if (SRST !== 1'b0 || WE !== 1'b1 || DOUT !== 8'h3B) begin
         failures++;
         $display("FAIL nack_ptr_retry: SRST=%b WE=%b DOUT=%h required 0 1 3b", SRST, WE, DOUT);
      end
      do_burst(14, 8'h30);
      step(E_ST, 8'h00);
      checks++;
      if (SCAN_CNT !== 8'd3 || ERR !== 1'b0 || COMPLETED !== 1'b1) begin
         failures++;
         $display("FAIL nack_ptr_done: SCAN_CNT=%0d ERR=%b COMPLETED=%b required 3 0 1",
                  SCAN_CNT, ERR, COMPLETED);
      end
   endtask

   task automatic test_nack_error;
      step(E_RS, 8'h00);
      for (int k = 0; k < 3; k++) begin
         step(E_NONE, 8'h00);
         step(E_NK, 8'h00);
         checks++;
         if (ERR !== (k == 2) || SRST !== 1'b1 || COMPLETED !== 1'b0) begin
            failures++;
            $display("FAIL nack%0d: ERR=%b SRST=%b COMPLETED=%b required %b 1 0",
                     k, ERR, SRST, COMPLETED, (k == 2));
         end
      end
      repeat (2) step(E_NONE, 8'h00);
      checks++;
      if (ERR !== 1'b1 || WE !== 1'b0) begin
         failures++; $display("FAIL err_hold: ERR=%b WE=%b required 1 0", ERR, WE);
      end
      step(E_RS, 8'h00);
      checks++;
      if (ERR !== 1'b0) begin
         failures++; $display("FAIL err_clear: ERR=%b required 0", ERR);
      end
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h6B) begin
         failures++; $display("FAIL reconfig: WE=%b DOUT=%h required 1 6b", WE, DOUT);
      end
      step(E_Q, 8'h00);
      step(E_Q, 8'h00);
      step(E_ST, 8'h00);
   endtask

   task automatic test_early_stop;
      do_burst(5, 8'h50);
      step(E_ST, 8'h00);
      checks++;
      if (SRST !== 1'b1 || RD !== 1'b0 || ERR !== 1'b0 || COMPLETED !== 1'b0) begin
         failures++;
         $display("FAIL early_stop: SRST=%b RD=%b ERR=%b COMPLETED=%b required 1 0 0 0",
                  SRST, RD, ERR, COMPLETED);
      end
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h3B) begin
         failures++; $display("FAIL early_retry: WE=%b DOUT=%h required 1 3b", WE, DOUT);
      end
      do_burst(14, 8'h40);
      step(E_ST, 8'h00);
      checks++;
      if (SCAN_CNT !== 8'd4 || COMPLETED !== 1'b1 || DATA !== 8'h4D) begin
         failures++;
         $display("FAIL early_done: SCAN_CNT=%0d COMPLETED=%b DATA=%h required 4 1 4d",
                  SCAN_CNT, COMPLETED, DATA);
      end
   endtask

   task automatic test_tic_gating;
      TIC = 1'b0;
      step(E_RS, 8'h00);
      step(E_NONE, 8'h00);
      TIC = 1'b1;
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b0 || COMPLETED !== 1'b1) begin
         failures++; $display("FAIL tic_gate: WE=%b COMPLETED=%b required 0 1", WE, COMPLETED);
      end
   endtask

   task automatic test_reset_mid_read;
      step(E_RS, 8'h00);
      step(E_NONE, 8'h00);
      step(E_Q, 8'h00);
      step(E_Q, 8'h00);
      step(E_DV, 8'h55);
      TIC = 1'b0;
      step(E_NONE, 8'h00);
      checks++;
      if (LOAD !== 1'b0 || DATA !== 8'h55) begin
         failures++; $display("FAIL load_no_tic: LOAD=%b DATA=%h required 0 55", LOAD, DATA);
      end
      TIC = 1'b1;
      nRST = 1'b0;
      step(E_NONE, 8'h00);
      checks++;
      if ({SRST, DOUT, WE, RD, ADR, DATA, LOAD, COMPLETED, ERR, SCAN_CNT} !== RST_EXP) begin
         failures++;
         $display("FAIL reset_mid_read: got %h required %h",
                  {SRST, DOUT, WE, RD, ADR, DATA, LOAD, COMPLETED, ERR, SCAN_CNT}, RST_EXP);
      end
      nRST = 1'b1;
      step(E_NONE, 8'h00);
      checks++;
      if (WE !== 1'b1 || DOUT !== 8'h6B) begin
         failures++; $display("FAIL post_reset_cfg: WE=%b DOUT=%h required 1 6b", WE, DOUT);
      end
   endtask

   task automatic test_auto_scan_n1;
      tgt = 1'b1;
      checks++;
      if (WE1 !== 1'b1 || DOUT1 !== 8'h6B) begin
         failures++; $display("FAIL n1_cfg: WE=%b DOUT=%h required 1 6b", WE1, DOUT1);
      end
      step(E_Q, 8'h00);
      step(E_Q, 8'h00);
      step(E_ST, 8'h00);
      step(E_Q, 8'h00);
      checks++;
      if (RD1 !== 1'b1) begin
         failures++; $display("FAIL n1_rd_start: RD=%b required 1", RD1);
      end
      step(E_Q, 8'h00);
      checks++;
      if (RD1 !== 1'b0) begin
         failures++; $display("FAIL n1_rd_drop: RD=%b required 0", RD1);
      end
      step(E_DV, 8'h77);
      checks++;
      if (LOAD1 !== 1'b1 || ADR1 !== 1'b0 || DATA1 !== 8'h77) begin
         failures++;
         $display("FAIL n1_load: LOAD=%b ADR=%0d DATA=%h required 1 0 77", LOAD1, ADR1, DATA1);
      end
      step(E_ST, 8'h00);
      checks++;
      if (COMPLETED1 !== 1'b1 || SCAN_CNT1 !== 8'd1) begin
         failures++;
         $display("FAIL n1_done: COMPLETED=%b SCAN_CNT=%0d required 1 1", COMPLETED1, SCAN_CNT1);
      end
      step(E_NONE, 8'h00);
      step(E_NONE, 8'h00);
      checks++;
      if (WE1 !== 1'b1 || DOUT1 !== 8'h3B) begin
         failures++; $display("FAIL auto_scan: WE=%b DOUT=%h required 1 3b", WE1, DOUT1);
      end
      tgt = 1'b0;
   endtask

   initial begin
      test_reset;
      test_first_scan;
      test_rescan;
      test_nack_ptr;
      test_nack_error;
      test_early_stop;
      test_tic_gating;
      test_reset_mid_read;
      test_auto_scan_n1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imu_burst_sequencer.md
# imu_burst_sequencer

Parametrised I2C register-burst sequencer that sits between the byte-level I2C master and the sensor data registers. It configures the sensor once after reset, then repeatedly reads N_BYTES consecutive registers starting at START_REG. Each byte is presented with its index for loading into the sample register file. It adds bounded NACK retry with master soft-reset, an error state, auto-rescan mode and a scan counter.

## Interface
- N_BYTES, 14: bytes per burst, 1..2**ADR_W
- ADR_W, 4: width of ADR
- START_REG, 8'h3B: first register address of the burst
- CFG_REG, 8'h6B: configuration register written once after reset
- CFG_VAL, 8'h00: value written to CFG_REG
- MAX_RETRY, 3: NACK restarts allowed per scan before ERROR, 1..7
- AUTO_SCAN, 0: 1 = start a new scan automatically from DONE; 0 = wait for RESCAN
- Clocking (already decided): one clock; reset is synchronous and active-low.
- MCLK  in  1  system clock
- nRST  in  1  synchronous active-low reset, sampled on MCLK rising edge
- TIC  in  1  bus-rate enable; all master-handshake decisions are taken only on cycles with TIC=1
- SRST  out  1  soft reset to I2C master, one MCLK pulse
- DOUT  out  8  byte to write to master
- WE  out  1  write request (DOUT valid)
- RD  out  1  read request
- QUEUED  in  1  master accepted the current WE/RD request
- NACK  in  1  slave not-acknowledged
- STOP  in  1  master finished transaction (stop condition sent)
- DATA_VALID  in  1  DIN holds a received byte
- DIN  in  8  received byte
- ADR  out  ADR_W  index of DATA within the burst
- DATA  out  8  received byte, captured
- LOAD  out  1  one-cycle strobe: DATA/ADR valid
- COMPLETED  out  1  level: last scan completed without error
- ERR  out  1  level: retries exhausted
- RESCAN  in  1  request new scan from DONE or ERROR
- SCAN_CNT  out  8  completed-scan counter, wraps 255->0

## Operation
- Reset values: SRST 0, DOUT 8'h00, WE 0, RD 0, ADR 0, DATA 8'hFF, LOAD 0, COMPLETED 0, ERR 0, SCAN_CNT 0; internal cfg_done 0, retry 0, req 0; state IDLE.
- Event priority in one TIC cycle: NACK > STOP > DATA_VALID > QUEUED.
- IDLE: on TIC -> CFG_A if cfg_done=0, else PTR. Clears COMPLETED.
- CFG_A: WE=1, DOUT=CFG_REG; QUEUED -> DOUT=CFG_VAL, CFG_B.
- CFG_B: QUEUED -> WE=0, cfg_done=1, WAIT_STOP.
- WAIT_STOP: STOP -> PTR.
- PTR: WE=1, RD=0, DOUT=START_REG; QUEUED -> WE=0, RD=1, req=0, ADR=0, READ.
- READ: QUEUED -> req+1; when req+1 = N_BYTES, RD=0 (no further read requests). DATA_VALID -> DATA=DIN, ADR=current index, LOAD=1 for one MCLK, index+1. STOP with N_BYTES bytes received -> DONE. STOP with fewer bytes received is treated as NACK.
- DONE: COMPLETED=1, SCAN_CNT+1 on entry, retry=0. TIC and (RESCAN or AUTO_SCAN=1) -> IDLE.
- NACK in CFG_A..READ: WE=0, RD=0, SRST=1 for one MCLK. If retry+1 < MAX_RETRY: retry+1, -> IDLE. Else -> ERROR.
- ERROR: ERR=1, COMPLETED=0; TIC and RESCAN -> ERR=0, retry=0, cfg_done=0, IDLE (full reconfigure).
- DATA is held between LOAD strobes; ADR never exceeds N_BYTES-1. Extra DATA_VALID after N_BYTES bytes is ignored.
- NACK/STOP/DATA_VALID/QUEUED in IDLE, DONE or ERROR are ignored.

## Timing
- Handshake inputs are sampled only when TIC=1. Outputs change on the same MCLK edge.
- LOAD and SRST deassert on the next MCLK regardless of TIC.
- DIN -> DATA/LOAD latency: 1 MCLK after the sampled DATA_VALID.
- Minimum scan, cfg_done=1: IDLE, PTR, READ, DONE = 3 + 2*N_BYTES TIC events, plus master time.
- Reset has priority over everything and takes effect mid-transaction: all outputs go to reset values on the next edge. It does not pulse SRST.

## Test plan
- Nominal first scan, N_BYTES=14: writes 6B, 00, then STOP, then 3B; 14 DIN bytes 8'h10..8'h1D -> 14 LOAD pulses, ADR 0..13, DATA matches, COMPLETED=1, SCAN_CNT=1.
- Second scan via RESCAN -> no CFG writes; first WE byte is 3B; SCAN_CNT=2. With AUTO_SCAN=1, the rescan starts without RESCAN.
- NACK during PTR once -> SRST one-cycle pulse, retry restarts at PTR, scan completes, ERR=0.
- NACK three times, MAX_RETRY=3 -> ERR=1, COMPLETED=0. RESCAN -> ERR=0 and reconfigure starts with DOUT=6B.
- Early STOP after 5 bytes -> retry path taken; extra DATA_VALID after 14 bytes -> no LOAD.
- nRST low mid-READ -> next edge gives DATA=FF, WE=RD=LOAD=0, SCAN_CNT=0; N_BYTES=1 variant: RD drops after first QUEUED.
